// File: rtl/ensemble_vote_collector.sv
// 2-of-3 majority vote collector for three classifier AXI-Stream result streams.
// Optional macro ENSEMBLE_VOTE_STATS_EN builds the non-unanimous sample counter.
module ensemble_vote_collector #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = 4,
  parameter int CLASS_WIDTH  = 8,
  parameter int TIE_PRIORITY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
  input  logic                  s_axis_tvalid_3,
  output logic                  s_axis_tready_3,
  input  logic                  s_axis_tlast_3,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  tlast_mismatch,
  output logic [31:0]           sample_count,
  output logic [31:0]           disagree_count
);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  function automatic logic [CLASS_WIDTH-1:0] vote_label(input logic [CLASS_WIDTH-1:0] a,
                                                        input logic [CLASS_WIDTH-1:0] b,
                                                        input logic [CLASS_WIDTH-1:0] c);
    if (a == b || a == c) return a;
    if (b == c) return b;
    case (TIE_PRIORITY)
      2:       return b;
      3:       return c;
      default: return a;
    endcase
  endfunction

  function automatic logic [1:0] vote_agree(input logic [CLASS_WIDTH-1:0] a,
                                            input logic [CLASS_WIDTH-1:0] b,
                                            input logic [CLASS_WIDTH-1:0] c);
    if (a == b && b == c) return 2'd3;
    if (a == b || a == c || b == c) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pack_word(input logic [CLASS_WIDTH-1:0] label,
                                                      input logic [1:0] agree);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[CLASS_WIDTH-1:0]   = label;
    w[CLASS_WIDTH +: 2]  = agree;
    return w;
  endfunction

  logic [2:0]             in_valid;
  logic [2:0]             in_last;
  logic [CLASS_WIDTH-1:0] in_label [3];
  logic [2:0]             capture;

  assign in_valid    = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};
  assign in_last     = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1};
  assign in_label[0] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign in_label[1] = s_axis_tdata_2[CLASS_WIDTH-1:0];
  assign in_label[2] = s_axis_tdata_3[CLASS_WIDTH-1:0];

  // TKEEP and the non-label data bits carry nothing the vote needs.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3,
                           s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_3[DATA_WIDTH-1:CLASS_WIDTH]};

  state_t                 state_q;
  logic [2:0]             held_q;
  logic [2:0]             last_q;
  logic [CLASS_WIDTH-1:0] label_q [3];
  logic                   m_tvalid_q;
  logic [DATA_WIDTH-1:0]  m_tdata_q;
  logic                   m_tlast_q;
  logic                   mismatch_q;
  logic [31:0]            sample_cnt_q;

  logic [CLASS_WIDTH-1:0] label_d;
  logic [1:0]             agree_d;
  logic [DATA_WIDTH-1:0]  word_d;
  logic                   last_d;
  logic                   mismatch_d;
  logic                   load;
  logic                   xfer;

  // Slots are only refilled once released, so capture never races the load.
  assign capture = in_valid & ~held_q;
  assign load    = (state_q == COLLECT) && (&held_q);
  assign xfer    = (state_q == EMIT) && m_axis_tready;

  always_comb begin
    label_d    = vote_label(label_q[0], label_q[1], label_q[2]);
    agree_d    = vote_agree(label_q[0], label_q[1], label_q[2]);
    word_d     = pack_word(label_d, agree_d);
    last_d     = |last_q;
    mismatch_d = (|last_q) && !(&last_q);
  end

  // Stage p0: per-input hold slot data
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (capture[i]) begin
        label_q[i] <= in_label[i];
        last_q[i]  <= in_last[i];
      end
    end
  end

  // Stage p1: slot occupancy, FSM and registered output word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      held_q       <= 3'b000;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      held_q <= load ? 3'b000 : (held_q | capture);
      case (state_q)
        COLLECT: begin
          if (load) begin
            m_tdata_q  <= word_d;
            m_tlast_q  <= last_d;
            m_tvalid_q <= 1'b1;
            if (mismatch_d) mismatch_q <= 1'b1;
            state_q    <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            m_tvalid_q   <= 1'b0;
            sample_cnt_q <= sample_cnt_q + 32'd1;
            state_q      <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef ENSEMBLE_VOTE_STATS_EN
  logic [31:0] disagree_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                         disagree_cnt_q <= '0;
    else if (load && agree_d != 2'd3) disagree_cnt_q <= disagree_cnt_q + 32'd1;
  end
  assign disagree_count = disagree_cnt_q;
`else
  assign disagree_count = '0;
`endif

  assign s_axis_tready_1 = ~held_q[0];
  assign s_axis_tready_2 = ~held_q[1];
  assign s_axis_tready_3 = ~held_q[2];
  assign m_axis_tvalid   = m_tvalid_q;
  assign m_axis_tdata    = m_tdata_q;
  assign m_axis_tlast    = m_tlast_q;
  assign m_axis_tkeep    = {KEEP_WIDTH{m_tvalid_q}};
  assign tlast_mismatch  = mismatch_q;
  assign sample_count    = sample_cnt_q;

endmodule
